uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//   Parametrised UART transmitter with an input FIFO and a runtime baud divisor.
//   It serialises words pushed over a valid/ready interface onto a single idle-high TX line, LSB first.
//   It sits between on-chip status/ID logic and the uo_out[4] TX pin.
//   It generalises the fixed 8N1 TX path: configurable data width, stop bits, FIFO depth and optional parity.
// PARAMETERS
//   DATA_BITS   8   bits per frame, legal range 5..8
//   STOP_BITS   1   stop bits per frame, legal values 1 or 2
//   FIFO_DEPTH  4   FIFO entries; must be a power of two, minimum 2
//   DIV_W       16  width of baud_div
// PORTS
//   clk         in   1                  system clock
//   rst         in   1                  asynchronous reset, active-high
//   baud_div    in   DIV_W              bit period = baud_div+1 clk cycles
//   in_data     in   DATA_BITS          word to transmit
//   in_valid    in   1                  in_data is valid
//   in_ready    out  1                  FIFO not full
//   tx          out  1                  serial line, idle high
//   busy        out  1                  frame in progress or FIFO non-empty
//   fifo_count  out  $clog2(FIFO_DEPTH)+1  number of FIFO entries
//   parity_odd  in   1                  present only with UART_TX_PARITY_EN; 1=odd, 0=even
// BEHAVIOUR
//   - Reset values: tx=1, in_ready=1, busy=0, fifo_count=0. FSM=IDLE, FIFO pointers=0.
//   - All outputs are registered, except in_ready = (fifo_count != FIFO_DEPTH).
//   - Push: in_valid && in_ready at a rising edge writes in_data. Full FIFO gives in_ready=0; no write, no bypass.
//   - Simultaneous push and pop in one cycle: fifo_count is unchanged. Pointers wrap modulo FIFO_DEPTH.
//   - FSM states and transitions:
//       IDLE   -> START   when the FIFO is non-empty; pops the head word into the shift register.
//       START  -> DATA    tx=0 for one bit period.
//       DATA   -> PARITY or STOP   shifts DATA_BITS bits out, LSB first.
//       PARITY -> STOP    only with UART_TX_PARITY_EN.
//       STOP   -> START or IDLE    tx=1 for STOP_BITS periods; goes to START if the FIFO is non-empty, otherwise IDLE.
//   - Back-to-back words: no idle gap between the stop bit and the next start bit.
//   - Latency: a push at edge N into an empty FIFO with the FSM in IDLE drives tx=0 from edge N+2.
//   - Baud counter: counts down from the latched divisor to 0, then advances one bit.
//       baud_div is latched on entry to START, so a change mid-frame takes effect at the next frame.
//       baud_div=0 gives one clk per bit.
//   - busy=1 from the cycle after the first push until the last stop period ends with the FIFO empty.
//   - Reset mid-frame: tx returns to 1 asynchronously, the FIFO is flushed and the frame is dropped.
// CONFIGURATION
//   UART_TX_PARITY_EN defined:
//     - parity_odd port exists.
//     - One parity bit follows the data: XOR of the data bits, XOR parity_odd.
//     - Frame length is 1 + DATA_BITS + 1 + STOP_BITS bits.
//   UART_TX_PARITY_EN undefined:
//     - No port, no PARITY state.
//     - Frame length is 1 + DATA_BITS + STOP_BITS bits.
// TESTING
//   1. 8N1, baud_div=3, push 0xA5
//        -> tx = 0,1,0,1,0,0,1,0,1,1, each level held 4 clks; 40 clks total; busy falls afterwards.
//   2. Push 0x01,0x02,0x03 back-to-back at baud_div=0
//        -> 30 contiguous bit cycles, no idle gap; fifo_count peaks at 2; data order preserved.
//   3. FIFO_DEPTH=4, baud_div=15, push 6 words with in_valid held high
//        -> in_ready drops once 4 entries are queued; the rest are accepted as the FSM drains; no word lost or duplicated.
//   4. UART_TX_PARITY_EN, 0xA5
//        -> parity bit 0 with parity_odd=0, 1 with parity_odd=1; frame is 11 bits.
//   5. Assert rst 5 clks into a DATA phase
//        -> tx=1 in the same cycle; fifo_count=0, busy=0; the next push transmits cleanly.
//   6. DATA_BITS=5, STOP_BITS=2, push 5'h1F
//        -> tx = 0,1,1,1,1,1,1,1; 8 bit periods.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Push-side handshake bundle for the UART transmitter.
// The producer owns data/valid and the transmitter answers with ready.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO and a runtime baud divisor.
// Words pushed over the valid/ready bundle are queued and sent LSB first
// on an idle-high line: start bit, DATA_BITS data bits, optional parity,
// STOP_BITS stop bits. Define UART_TX_PARITY_EN to add the parity bit and
// the parity_odd port.
// The tx level is registered from the current FSM state, so every bit
// appears on the pin one cycle after the state that produces it.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DIV_W-1:0]            baud_div,
  uart_tx_fifo_if.slave               bus,
`ifdef UART_TX_PARITY_EN
  input  logic                        parity_odd,
`endif
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0]   mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [DIV_W-1:0]       baud_cnt_q, baud_cnt_d;
  logic [BIT_W-1:0]       bit_idx_q, bit_idx_d;
  logic                   stop_idx_q, stop_idx_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif
  logic                   in_ready;
  logic                   push;
  logic                   pop;
  logic                   bit_done;
  logic [DATA_BITS-1:0]   head;

  assign in_ready     = (count_q != FULL_CNT);
  assign bus.in_ready = in_ready;
  assign push         = bus.in_valid && in_ready;
  assign head         = mem_q[rd_ptr_q];
  assign bit_done     = (baud_cnt_q == '0);

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;

  // Frame sequencer: walks start/data/(parity)/stop, and pops the next word
  // straight out of STOP so back-to-back frames have no idle gap.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    div_d      = div_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (count_q != '0) pop = 1'b1;
      end
      START: begin
        if (bit_done) begin
          state_d    = DATA;
          bit_idx_d  = '0;
          baud_cnt_d = div_q;
        end else begin
          baud_cnt_d = baud_cnt_q - DIV_W'(1);
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_cnt_d = div_q;
          if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
            shift_d   = shift_q >> 1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - DIV_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_d    = STOP;
          stop_idx_d = 1'b0;
          baud_cnt_d = div_q;
        end else begin
          baud_cnt_d = baud_cnt_q - DIV_W'(1);
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          baud_cnt_d = div_q;
          if (stop_idx_q == LAST_STOP) begin
            if (count_q != '0) pop = 1'b1;
            else               state_d = IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Starting a frame: take the head word and freeze the divisor for the
    // whole frame so mid-frame baud_div changes only affect the next one.
    if (pop) begin
      state_d    = START;
      shift_d    = head;
      div_d      = baud_div;
      baud_cnt_d = baud_div;
`ifdef UART_TX_PARITY_EN
      parity_d   = (^head) ^ parity_odd;
`endif
    end
  end

  // FIFO bookkeeping: pointers wrap naturally at the power-of-two depth and
  // a simultaneous push and pop leave the count unchanged.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = bus.in_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pin levels follow the current state one cycle later; busy covers the
  // push cycle, queued words and the frame until its last stop bit leaves.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_q;
`endif
      default: tx_d = 1'b1;
    endcase
    busy_d = push || (count_q != '0) || (state_q != IDLE);
  end

  // Queue storage needs no reset: the pointers decide what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Control and output registers; reset drops any frame in flight and
  // empties the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      shift_q    <= '0;
      div_q      <= '0;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      div_q      <= div_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: an 8-bit/1-stop/4-deep instance
// driven from a table of directed frames plus hand-written sequences, and a
// 5-bit/2-stop/2-deep instance for the narrow-frame case.
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME_LEN  = 1 + 8 + PAR_BITS + 1;
  localparam int FRAME6_LEN = 1 + 5 + PAR_BITS + 2;

  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    logic [9:0]  frame;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic        tx;
  logic        busy;
  logic [2:0]  fifo_count;
  logic [15:0] baud_div6;
  logic        tx6;
  logic        busy6;
  logic [1:0]  fifo_count6;
`ifdef UART_TX_PARITY_EN
  logic        parity_odd;
  logic        parity_odd6;
`endif

  int          checks   = 0;
  int          failures = 0;
  vec_t        vecs [5];
  logic [9:0]  b2b_frames [3];
  logic [11:0] exp;
  logic [11:0] exp6;
  logic [7:0]  words [6];
  logic [7:0]  got;
  logic        frame_ok;
  int          idx;
  int          guard;
  int          hits;
  int          peak;
  logic        rdy;
  logic        saw_full;
  logic [2:0]  full_cnt;

  uart_tx_fifo_if #(.DATA_BITS(8)) bus ();
  uart_tx_fifo_if #(.DATA_BITS(5)) bus6 ();

  uart_tx_fifo #(
    .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4), .DIV_W(16)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .baud_div(baud_div),
    .bus(bus),
`ifdef UART_TX_PARITY_EN
    .parity_odd(parity_odd),
`endif
    .tx(tx),
    .busy(busy),
    .fifo_count(fifo_count)
  );

  uart_tx_fifo #(
    .DATA_BITS(5), .STOP_BITS(2), .FIFO_DEPTH(2), .DIV_W(16)
  ) u_dut6 (
    .clk(clk),
    .rst(rst),
    .baud_div(baud_div6),
    .bus(bus6),
`ifdef UART_TX_PARITY_EN
    .parity_odd(parity_odd6),
`endif
    .tx(tx6),
    .busy(busy6),
    .fifo_count(fifo_count6)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // One comparison: count it, and report any difference.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Single-cycle push on the 8-bit instance; returns 1ns after the edge.
  task automatic applyStimulus(input logic [7:0] data);
    bus.in_data  = data;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Checks every cycle of one frame, starting with the cycle after the
  // current one, then the idle state that follows it.
  task automatic check_bits(input string name, input int div, input logic [11:0] e);
    int bit_hits;
    int busy_hits;
    busy_hits = 0;
    for (int b = 0; b < FRAME_LEN; b++) begin
      bit_hits = 0;
      for (int c = 0; c <= div; c++) begin
        @(posedge clk); #1;
        if (tx === e[b]) bit_hits++;
        if (busy === 1'b1) busy_hits++;
      end
      checkOutput($sformatf("%s_bit%0d", name, b), bit_hits, div + 1);
    end
    checkOutput({name, "_busy_in_frame"}, busy_hits, FRAME_LEN * (div + 1));
    @(posedge clk); #1;
    checkOutput({name, "_idle_tx"}, tx, 1);
    checkOutput({name, "_idle_busy"}, busy, 0);
    checkOutput({name, "_idle_count"}, fifo_count, 0);
  endtask

  // Called right after a push into an idle, empty transmitter.
  task automatic check_frame(input string name, input int div, input logic [11:0] e);
    @(posedge clk); #1;
    checkOutput({name, "_latency_tx_high"}, tx, 1);
    check_bits(name, div, e);
  endtask

  // Mid-bit sampling receiver for the 8-bit instance.
  task automatic rx_frame(input int period, output logic [7:0] data, output logic ok);
    int waitc;
    waitc = 0;
    ok    = 1'b1;
    data  = '0;
    while (tx !== 1'b0 && waitc < 5000) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (waitc >= 5000) begin
      ok = 1'b0;
      return;
    end
    repeat (period / 2) begin @(posedge clk); #1; end
    if (tx !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (period) begin @(posedge clk); #1; end
      data[i] = tx;
    end
`ifdef UART_TX_PARITY_EN
    repeat (period) begin @(posedge clk); #1; end
    if (tx !== ((^data) ^ parity_odd)) ok = 1'b0;
`endif
    repeat (period) begin @(posedge clk); #1; end
    if (tx !== 1'b1) ok = 1'b0;
  endtask

  // Keeps the run bounded even if the design wedges.
  initial begin
    #300000;
    failures++;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    vecs[0] = '{data: 8'hA5, div: 16'd3, frame: 10'b1101001010};
    vecs[1] = '{data: 8'h00, div: 16'd0, frame: 10'b1000000000};
    vecs[2] = '{data: 8'hFF, div: 16'd1, frame: 10'b1111111110};
    vecs[3] = '{data: 8'h3C, div: 16'd2, frame: 10'b1001111000};
    vecs[4] = '{data: 8'h81, div: 16'd0, frame: 10'b1100000010};
    b2b_frames[0] = 10'b1000000010;
    b2b_frames[1] = 10'b1000000100;
    b2b_frames[2] = 10'b1000000110;
    words[0] = 8'h10; words[1] = 8'h21; words[2] = 8'h32;
    words[3] = 8'h43; words[4] = 8'h54; words[5] = 8'h65;

    rst           = 1'b1;
    baud_div      = 16'd3;
    baud_div6     = 16'd1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus6.in_valid = 1'b0;
    bus6.in_data  = '0;
`ifdef UART_TX_PARITY_EN
    parity_odd    = 1'b0;
    parity_odd6   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_tx", tx, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_count", fifo_count, 0);
    checkOutput("reset_in_ready", bus.in_ready, 1);
    checkOutput("reset_tx6", tx6, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] table-driven single frames");
    for (int v = 0; v < 5; v++) begin
      exp = {2'b00, vecs[v].frame};
`ifdef UART_TX_PARITY_EN
      exp = {1'b1, ^vecs[v].data, vecs[v].frame[8:1], 1'b0};
`endif
      baud_div = vecs[v].div;
      applyStimulus(vecs[v].data);
      check_frame($sformatf("vec%0d", v), int'(vecs[v].div), exp);
    end

    $display("[TB] divisor latched at frame start");
    baud_div = 16'd2;
    exp = {2'b00, 10'b1100101100};
`ifdef UART_TX_PARITY_EN
    exp = {1'b1, 1'b0, 8'h96, 1'b0};
`endif
    applyStimulus(8'h96);
    @(posedge clk); #1;
    baud_div = 16'd0;
    check_bits("divlatch", 2, exp);

    $display("[TB] back-to-back words");
    baud_div     = 16'd0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h01;
    @(posedge clk); #1;
    checkOutput("b2b_count_after_1", fifo_count, 1);
    bus.in_data = 8'h02;
    @(posedge clk); #1;
    checkOutput("b2b_count_after_2", fifo_count, 1);
    bus.in_data = 8'h03;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checkOutput("b2b_count_after_3", fifo_count, 2);
    peak = 0;
    for (int f = 0; f < 3; f++) begin
      exp = {2'b00, b2b_frames[f]};
`ifdef UART_TX_PARITY_EN
      exp = {1'b1, ^b2b_frames[f][8:1], b2b_frames[f][8:1], 1'b0};
`endif
      hits = 0;
      for (int b = 0; b < FRAME_LEN; b++) begin
        if (f != 0 || b != 0) begin @(posedge clk); #1; end
        if (tx === exp[b]) hits++;
        if (int'(fifo_count) > peak) peak = int'(fifo_count);
      end
      checkOutput($sformatf("b2b_frame%0d", f), hits, FRAME_LEN);
    end
    checkOutput("b2b_count_peak", peak, 2);
    @(posedge clk); #1;
    checkOutput("b2b_idle_tx", tx, 1);
    checkOutput("b2b_idle_busy", busy, 0);

    $display("[TB] FIFO full backpressure");
    baud_div = 16'd15;
    idx      = 0;
    guard    = 0;
    saw_full = 1'b0;
    full_cnt = '0;
    fork
      begin
        bus.in_data  = words[0];
        bus.in_valid = 1'b1;
        while (idx < 6 && guard < 4000) begin
          rdy = bus.in_ready;
          if (!rdy) begin
            saw_full = 1'b1;
            full_cnt = fifo_count;
          end
          @(posedge clk); #1;
          guard++;
          if (rdy) begin
            idx++;
            if (idx < 6) bus.in_data = words[idx];
          end
        end
        bus.in_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 6; k++) begin
          rx_frame(16, got, frame_ok);
          checkOutput($sformatf("full_word%0d", k), got, words[k]);
          checkOutput($sformatf("full_frame_ok%0d", k), frame_ok, 1);
        end
      end
    join
    checkOutput("full_accepted", idx, 6);
    checkOutput("full_ready_dropped", saw_full, 1);
    checkOutput("full_count_when_blocked", full_cnt, 4);
    guard = 0;
    while (busy !== 1'b0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("full_drain_busy", busy, 0);
    checkOutput("full_drain_count", fifo_count, 0);

`ifdef UART_TX_PARITY_EN
    $display("[TB] parity bit");
    baud_div   = 16'd1;
    parity_odd = 1'b0;
    applyStimulus(8'hA5);
    check_frame("par_even", 1, 12'b0_1_0_10100101_0);
    parity_odd = 1'b1;
    applyStimulus(8'hA5);
    check_frame("par_odd", 1, 12'b0_1_1_10100101_0);
    parity_odd = 1'b0;
`endif

    $display("[TB] reset during data phase");
    baud_div = 16'd3;
    applyStimulus(8'hA5);
    bus.in_data  = 8'h3C;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    checkOutput("rst_pre_tx_data_bit1", tx, 0);
    checkOutput("rst_pre_count", fifo_count, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_async_tx", tx, 1);
    checkOutput("rst_async_count", fifo_count, 0);
    checkOutput("rst_async_busy", busy, 0);
    checkOutput("rst_async_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    exp = {2'b00, 10'b1010110100};
`ifdef UART_TX_PARITY_EN
    exp = {1'b1, 1'b0, 8'h5A, 1'b0};
`endif
    applyStimulus(8'h5A);
    check_frame("rst_after", 3, exp);

    $display("[TB] 5 data bits, 2 stop bits");
    exp6 = 12'b0000_1111_1110;
`ifdef UART_TX_PARITY_EN
    exp6 = 12'b0001_1111_1110;
`endif
    bus6.in_data  = 5'h1F;
    bus6.in_valid = 1'b1;
    @(posedge clk); #1;
    bus6.in_valid = 1'b0;
    checkOutput("n5_count", fifo_count6, 1);
    @(posedge clk); #1;
    checkOutput("n5_latency_tx_high", tx6, 1);
    for (int b = 0; b < FRAME6_LEN; b++) begin
      hits = 0;
      for (int c = 0; c < 2; c++) begin
        @(posedge clk); #1;
        if (tx6 === exp6[b]) hits++;
      end
      checkOutput($sformatf("n5_bit%0d", b), hits, 2);
    end
    @(posedge clk); #1;
    checkOutput("n5_idle_tx", tx6, 1);
    checkOutput("n5_idle_busy", busy6, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
